// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-number type and forwarding-select encoding.
package cpu_types_pkg;

  // Architectural register file size; register 0 is hard-wired to zero.
  localparam int unsigned NUM_REGS = 32;

  // Register number as carried through the pipeline.
  typedef logic [4:0] regbits_t;

  // fwd_sel value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  // fwd_sel value that selects producer stage index stg (0 = youngest).
  function automatic int fwd_stage_code(input int stg);
    return stg + 1;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Signal bundle between the DX stage / producer stages and the hazard unit.
interface hazard_fwd_unit_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_STG = 2,
  parameter int unsigned MAX_LAT = 7
);

  localparam int unsigned SELW = $clog2(NUM_STG + 1);
  localparam int unsigned LATW = $clog2(MAX_LAT + 1);

  // DX consumer side
  cpu_types_pkg::regbits_t [NUM_SRC-1:0] dx_rs;
  logic [NUM_SRC-1:0]                    dx_rs_used;

  // Producer stages, index 0 = youngest
  cpu_types_pkg::regbits_t [NUM_STG-1:0] stg_rd;
  logic [NUM_STG-1:0]                    stg_regWr;
  logic [NUM_STG-1:0]                    stg_dvalid;

  // Instruction leaving DX
  logic                    issue_valid;
  cpu_types_pkg::regbits_t issue_rd;
  logic [LATW-1:0]         issue_lat;
  logic                    flush;

  // Results
  logic [NUM_SRC-1:0][SELW-1:0] fwd_sel;
  logic                         stall;
  logic [31:0]                  sb_busy;
  logic [31:0]                  stall_cycles;

  modport hfu (
    input  dx_rs, dx_rs_used, stg_rd, stg_regWr, stg_dvalid,
    input  issue_valid, issue_rd, issue_lat, flush,
    output fwd_sel, stall, sb_busy, stall_cycles
  );

  modport tb (
    output dx_rs, dx_rs_used, stg_rd, stg_regWr, stg_dvalid,
    output issue_valid, issue_rd, issue_lat, flush,
    input  fwd_sel, stall, sb_busy, stall_cycles
  );

endinterface

// File: rtl/sb_counter.sv
// One scoreboard entry: countdown until a long-latency result is forwardable.
module sb_counter #(
  parameter int unsigned MAX_LAT = 7
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic                           clr,
  input  logic                           load,
  input  logic [$clog2(MAX_LAT+1)-1:0]   load_val,
  output logic                           busy
);

  localparam int unsigned CW = $clog2(MAX_LAT + 1);

  logic [CW-1:0] lat_sat_s;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  // Clamp the requested latency to the largest countdown supported.
  always_comb begin
    if (32'(load_val) > MAX_LAT) begin
      lat_sat_s = CW'(MAX_LAT);
    end else begin
      lat_sat_s = load_val;
    end
  end

  // Next count: flush clears, a new issue reloads, otherwise count down to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (load) begin
      cnt_d = lat_sat_s;
    end else if (cnt_q != {CW{1'b0}}) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Countdown state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != {CW{1'b0}});

endmodule

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding select, load-use / scoreboard stall and stall statistics.
module hazard_fwd_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_STG = 2,
  parameter int unsigned MAX_LAT = 7
) (
  input logic            CLK,
  input logic            nRST,
  hazard_fwd_unit_if.hfu bus
);

  localparam int unsigned SELW = $clog2(NUM_STG + 1);
  localparam int unsigned LATW = $clog2(MAX_LAT + 1);

  logic [NUM_SRC-1:0][SELW-1:0] fwd_sel_s;
  logic [NUM_SRC-1:0]           load_use_s;
  logic [NUM_SRC-1:0]           ready_hit_s;
  logic [NUM_SRC-1:0]           sb_wait_s;
  logic                         stall_s;
  logic                         issue_go_s;
  logic [NUM_REGS-1:0]          sb_busy_s;
  logic [31:0]                  stall_cycles_d;
  logic [31:0]                  stall_cycles_q;

  // Per source: youngest matching writer wins; flag stale loads and
  // scoreboard entries that no ready producer can cover.
  always_comb begin
    fwd_sel_s   = '0;
    load_use_s  = '0;
    ready_hit_s = '0;
    sb_wait_s   = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (bus.dx_rs_used[s] && (bus.dx_rs[s] != 5'd0)) begin
        // Walk oldest to youngest so the youngest match is written last.
        for (int k = NUM_STG - 1; k >= 0; k--) begin
          if (bus.stg_regWr[k] && (bus.stg_rd[k] == bus.dx_rs[s])) begin
            fwd_sel_s[s]   = SELW'(fwd_stage_code(k));
            load_use_s[s]  = ~bus.stg_dvalid[k];
            ready_hit_s[s] = ready_hit_s[s] | bus.stg_dvalid[k];
          end else begin
            fwd_sel_s[s] = fwd_sel_s[s];
          end
        end
        sb_wait_s[s] = sb_busy_s[bus.dx_rs[s]] & ~ready_hit_s[s];
      end else begin
        fwd_sel_s[s] = SELW'(FWD_RF);
      end
    end
  end

  assign stall_s = (|load_use_s) | (|sb_wait_s);

  // Only an instruction that actually leaves DX with a real latency and a
  // real destination claims a scoreboard entry.
  assign issue_go_s = bus.issue_valid & ~stall_s &
                      (bus.issue_rd != 5'd0) &
                      (bus.issue_lat != {LATW{1'b0}});

  // Register 0 is never tracked.
  assign sb_busy_s[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    logic load_s;
    assign load_s = issue_go_s & (bus.issue_rd == 5'(r));

    sb_counter #(
      .MAX_LAT (MAX_LAT)
    ) u_sb_counter (
      .CLK      (CLK),
      .nRST     (nRST),
      .clr      (bus.flush),
      .load     (load_s),
      .load_val (bus.issue_lat),
      .busy     (sb_busy_s[r])
    );
  end

  // Saturating count of cycles spent stalled.
  always_comb begin
    if (stall_s && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Stall statistics register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.fwd_sel      = fwd_sel_s;
  assign bus.stall        = stall_s;
  assign bus.sb_busy      = sb_busy_s;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed testbench for hazard_fwd_unit.
module tb_hazard_fwd_unit;

  logic clk = 1'b0;
  logic nrst;
  int   n_vec = 0;
  int   n_err = 0;
  int   sc_exp = 0;

  hazard_fwd_unit_if ifc ();

  hazard_fwd_unit dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifc.dx_rs       = '0;
    ifc.dx_rs_used  = 2'b00;
    ifc.stg_rd      = '0;
    ifc.stg_regWr   = 2'b00;
    ifc.stg_dvalid  = 2'b00;
    ifc.issue_valid = 1'b0;
    ifc.issue_rd    = 5'd0;
    ifc.issue_lat   = 3'd0;
    ifc.flush       = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    nrst = 1'b0;
    #12;
    nrst = 1'b1;
    tick();
    n_vec++; if (ifc.fwd_sel !== 4'd0) begin n_err++; $display("FAIL reset_fwd_sel: got %0h want 0", ifc.fwd_sel); end
    n_vec++; if (ifc.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0h want 0", ifc.stall); end
    n_vec++; if (ifc.sb_busy !== 32'd0) begin n_err++; $display("FAIL reset_sb_busy: got %h want 0", ifc.sb_busy); end
    n_vec++; if (ifc.stall_cycles !== 32'd0) begin n_err++; $display("FAIL reset_stall_cycles: got %0d want 0", ifc.stall_cycles); end
  endtask

  task automatic test_forward();
    clear_inputs();
    ifc.dx_rs[0] = 5'd5; ifc.dx_rs_used = 2'b01;
    ifc.stg_rd[0] = 5'd5; ifc.stg_rd[1] = 5'd5;
    ifc.stg_regWr = 2'b11; ifc.stg_dvalid = 2'b11;
    #1;
    n_vec++; if (ifc.fwd_sel[0] !== 2'd1) begin n_err++; $display("FAIL fwd_youngest: got %0d want 1", ifc.fwd_sel[0]); end
    n_vec++; if (ifc.stall !== 1'b0) begin n_err++; $display("FAIL fwd_youngest_stall: got %0d want 0", ifc.stall); end
    n_vec++; if (ifc.fwd_sel[1] !== 2'd0) begin n_err++; $display("FAIL fwd_unused_src1: got %0d want 0", ifc.fwd_sel[1]); end
    ifc.stg_regWr = 2'b10;
    #1;
    n_vec++; if (ifc.fwd_sel[0] !== 2'd2) begin n_err++; $display("FAIL fwd_older: got %0d want 2", ifc.fwd_sel[0]); end
    ifc.dx_rs_used = 2'b00;
    #1;
    n_vec++; if (ifc.fwd_sel[0] !== 2'd0) begin n_err++; $display("FAIL fwd_not_used: got %0d want 0", ifc.fwd_sel[0]); end
    ifc.dx_rs[0] = 5'd0; ifc.dx_rs_used = 2'b01;
    ifc.stg_rd[0] = 5'd0; ifc.stg_rd[1] = 5'd0;
    ifc.stg_regWr = 2'b11; ifc.stg_dvalid = 2'b00;
    #1;
    n_vec++; if (ifc.fwd_sel[0] !== 2'd0) begin n_err++; $display("FAIL fwd_r0: got %0d want 0", ifc.fwd_sel[0]); end
    n_vec++; if (ifc.stall !== 1'b0) begin n_err++; $display("FAIL stall_r0: got %0d want 0", ifc.stall); end
    ifc.dx_rs[0] = 5'd5; ifc.stg_rd[0] = 5'd5; ifc.stg_rd[1] = 5'd5;
    ifc.stg_dvalid = 2'b10;
    #1;
    n_vec++; if (ifc.fwd_sel[0] !== 2'd1) begin n_err++; $display("FAIL fwd_stale_young: got %0d want 1", ifc.fwd_sel[0]); end
    n_vec++; if (ifc.stall !== 1'b1) begin n_err++; $display("FAIL stall_stale_young: got %0d want 1", ifc.stall); end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ifc.dx_rs[1] = 5'd7; ifc.dx_rs_used = 2'b10;
    ifc.stg_rd[0] = 5'd7; ifc.stg_regWr = 2'b01; ifc.stg_dvalid = 2'b00;
    #1;
    n_vec++; if (ifc.stall !== 1'b1) begin n_err++; $display("FAIL load_use_stall: got %0d want 1", ifc.stall); end
    n_vec++; if (ifc.fwd_sel[1] !== 2'd1) begin n_err++; $display("FAIL load_use_fwd: got %0d want 1", ifc.fwd_sel[1]); end
    for (int i = 0; i < 3; i++) begin
      tick();
      sc_exp++;
      n_vec++; if (ifc.stall_cycles !== 32'(sc_exp)) begin n_err++; $display("FAIL load_use_count: got %0d want %0d", ifc.stall_cycles, sc_exp); end
    end
    clear_inputs();
    #1;
    n_vec++; if (ifc.stall !== 1'b0) begin n_err++; $display("FAIL load_use_release: got %0d want 0", ifc.stall); end
    tick();
    n_vec++; if (ifc.stall_cycles !== 32'(sc_exp)) begin n_err++; $display("FAIL load_use_hold: got %0d want %0d", ifc.stall_cycles, sc_exp); end
  endtask

  task automatic test_scoreboard();
    clear_inputs();
    ifc.issue_valid = 1'b1; ifc.issue_rd = 5'd9; ifc.issue_lat = 3'd3;
    #1;
    n_vec++; if (ifc.sb_busy !== 32'd0) begin n_err++; $display("FAIL sb_before_issue: got %h want 0", ifc.sb_busy); end
    tick();
    clear_inputs();
    ifc.dx_rs[0] = 5'd9; ifc.dx_rs_used = 2'b01;
    ifc.issue_valid = 1'b1; ifc.issue_rd = 5'd12; ifc.issue_lat = 3'd2;
    #1;
    n_vec++; if (ifc.sb_busy !== 32'h0000_0200) begin n_err++; $display("FAIL sb_c1_busy: got %h want 00000200", ifc.sb_busy); end
    n_vec++; if (ifc.stall !== 1'b1) begin n_err++; $display("FAIL sb_c1_stall: got %0d want 1", ifc.stall); end
    tick(); sc_exp++;
    ifc.issue_valid = 1'b0;
    #1;
    n_vec++; if (ifc.sb_busy !== 32'h0000_0200) begin n_err++; $display("FAIL sb_c2_busy_ignored_issue: got %h want 00000200", ifc.sb_busy); end
    n_vec++; if (ifc.stall !== 1'b1) begin n_err++; $display("FAIL sb_c2_stall: got %0d want 1", ifc.stall); end
    tick(); sc_exp++;
    n_vec++; if (ifc.sb_busy !== 32'h0000_0200) begin n_err++; $display("FAIL sb_c3_busy: got %h want 00000200", ifc.sb_busy); end
    n_vec++; if (ifc.stall !== 1'b1) begin n_err++; $display("FAIL sb_c3_stall: got %0d want 1", ifc.stall); end
    tick(); sc_exp++;
    n_vec++; if (ifc.sb_busy !== 32'd0) begin n_err++; $display("FAIL sb_expired: got %h want 0", ifc.sb_busy); end
    n_vec++; if (ifc.stall !== 1'b0) begin n_err++; $display("FAIL sb_expired_stall: got %0d want 0", ifc.stall); end
    n_vec++; if (ifc.stall_cycles !== 32'(sc_exp)) begin n_err++; $display("FAIL sb_stall_count: got %0d want %0d", ifc.stall_cycles, sc_exp); end
    clear_inputs();
    tick();
  endtask

  task automatic test_busy_bypass();
    clear_inputs();
    ifc.issue_valid = 1'b1; ifc.issue_rd = 5'd9; ifc.issue_lat = 3'd2;
    tick();
    clear_inputs();
    ifc.dx_rs[0] = 5'd9; ifc.dx_rs_used = 2'b01;
    ifc.stg_rd[1] = 5'd9; ifc.stg_regWr = 2'b10; ifc.stg_dvalid = 2'b10;
    #1;
    n_vec++; if (ifc.stall !== 1'b0) begin n_err++; $display("FAIL bypass_stall: got %0d want 0", ifc.stall); end
    n_vec++; if (ifc.fwd_sel[0] !== 2'd2) begin n_err++; $display("FAIL bypass_fwd: got %0d want 2", ifc.fwd_sel[0]); end
    ifc.stg_dvalid = 2'b00;
    #1;
    n_vec++; if (ifc.stall !== 1'b1) begin n_err++; $display("FAIL bypass_not_ready: got %0d want 1", ifc.stall); end
    ifc.stg_dvalid = 2'b10;
    tick();
    tick();
    n_vec++; if (ifc.sb_busy !== 32'd0) begin n_err++; $display("FAIL bypass_expired: got %h want 0", ifc.sb_busy); end
    n_vec++; if (ifc.stall_cycles !== 32'(sc_exp)) begin n_err++; $display("FAIL bypass_count: got %0d want %0d", ifc.stall_cycles, sc_exp); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    ifc.issue_valid = 1'b1; ifc.issue_rd = 5'd9; ifc.issue_lat = 3'd3;
    tick();
    ifc.issue_lat = 3'd2;
    #1;
    n_vec++; if (ifc.sb_busy !== 32'h0000_0200) begin n_err++; $display("FAIL b2b_c1: got %h want 00000200", ifc.sb_busy); end
    tick();
    clear_inputs();
    tick();
    n_vec++; if (ifc.sb_busy !== 32'h0000_0200) begin n_err++; $display("FAIL b2b_c3: got %h want 00000200", ifc.sb_busy); end
    tick();
    n_vec++; if (ifc.sb_busy !== 32'd0) begin n_err++; $display("FAIL b2b_clear: got %h want 0", ifc.sb_busy); end
    ifc.issue_valid = 1'b1; ifc.issue_rd = 5'd9; ifc.issue_lat = 3'd3;
    tick();
    ifc.issue_lat = 3'd6;
    tick();
    clear_inputs();
    for (int i = 0; i < 5; i++) tick();
    n_vec++; if (ifc.sb_busy !== 32'h0000_0200) begin n_err++; $display("FAIL reload_longer_busy: got %h want 00000200", ifc.sb_busy); end
    tick();
    n_vec++; if (ifc.sb_busy !== 32'd0) begin n_err++; $display("FAIL reload_longer_clear: got %h want 0", ifc.sb_busy); end
  endtask

  task automatic test_flush();
    clear_inputs();
    ifc.issue_valid = 1'b1; ifc.issue_rd = 5'd4; ifc.issue_lat = 3'd5;
    tick();
    ifc.issue_rd = 5'd10; ifc.issue_lat = 3'd7;
    tick();
    ifc.issue_rd = 5'd4; ifc.issue_lat = 3'd2; ifc.flush = 1'b1;
    #1;
    n_vec++; if (ifc.sb_busy !== 32'h0000_0410) begin n_err++; $display("FAIL flush_pre: got %h want 00000410", ifc.sb_busy); end
    tick();
    clear_inputs();
    #1;
    n_vec++; if (ifc.sb_busy !== 32'd0) begin n_err++; $display("FAIL flush_clear: got %h want 0", ifc.sb_busy); end
    tick();
    n_vec++; if (ifc.sb_busy !== 32'd0) begin n_err++; $display("FAIL flush_hold: got %h want 0", ifc.sb_busy); end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    ifc.issue_valid = 1'b1; ifc.issue_rd = 5'd3; ifc.issue_lat = 3'd7;
    tick();
    clear_inputs();
    #1;
    n_vec++; if (ifc.sb_busy !== 32'h0000_0008) begin n_err++; $display("FAIL arst_pre_busy: got %h want 00000008", ifc.sb_busy); end
    n_vec++; if (ifc.stall_cycles !== 32'(sc_exp)) begin n_err++; $display("FAIL arst_pre_count: got %0d want %0d", ifc.stall_cycles, sc_exp); end
    #2;
    nrst = 1'b0;
    #1;
    sc_exp = 0;
    n_vec++; if (ifc.sb_busy !== 32'd0) begin n_err++; $display("FAIL arst_busy: got %h want 0", ifc.sb_busy); end
    n_vec++; if (ifc.stall_cycles !== 32'd0) begin n_err++; $display("FAIL arst_count: got %0d want 0", ifc.stall_cycles); end
    n_vec++; if (ifc.stall !== 1'b0) begin n_err++; $display("FAIL arst_stall: got %0d want 0", ifc.stall); end
    n_vec++; if (ifc.fwd_sel !== 4'd0) begin n_err++; $display("FAIL arst_fwd: got %0h want 0", ifc.fwd_sel); end
    #2;
    nrst = 1'b1;
    tick();
    ifc.issue_valid = 1'b1; ifc.issue_rd = 5'd0; ifc.issue_lat = 3'd3;
    #1;
    n_vec++; if (ifc.stall !== 1'b0) begin n_err++; $display("FAIL r0_issue_stall: got %0d want 0", ifc.stall); end
    tick();
    clear_inputs();
    #1;
    n_vec++; if (ifc.sb_busy !== 32'd0) begin n_err++; $display("FAIL r0_issue_busy: got %h want 0", ifc.sb_busy); end
    n_vec++; if (ifc.stall_cycles !== 32'd0) begin n_err++; $display("FAIL r0_issue_count: got %0d want 0", ifc.stall_cycles); end
  endtask

  initial begin
    nrst = 1'b0;
    clear_inputs();
    test_reset();
    test_forward();
    test_load_use();
    test_scoreboard();
    test_busy_bypass();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
